// File: rtl/home_auto_pkg.sv
// Shared types and helpers for the home-automation sequencer.
package home_auto_pkg;

  typedef enum logic [1:0] {LOCKED, UNLOCKED, LOCKOUT} lock_state_e;
  typedef enum logic [1:0] {OFF, FAN, AC} climate_mode_e;

  // Saturating subtract; callers cast the result back to their code width.
  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/auto_lock_fsm.sv
// Password lock FSM with retry limit, timed lockout and, when HOME_AUTO_RELOCK_EN
// is defined, an inactivity relock timer.
//   state    | meaning
//   LOCKED   | waiting for a code, tries_left attempts remain
//   UNLOCKED | access granted, climate and lights active
//   LOCKOUT  | too many wrong codes, codes ignored until timer expires
module auto_lock_fsm
  import home_auto_pkg::*;
#(
  parameter int DW = 4,
  parameter logic [DW-1:0] PASS = 4'b0010,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYC = 16,
  parameter int RELOCK_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [DW-1:0] pass_in_i,
  input  logic pass_valid_i,
  input  logic lock_req_i,
`ifdef HOME_AUTO_RELOCK_EN
  input  logic act_i,
`endif
  output lock_state_e state_o,
  output lock_state_e state_d_o,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left_o
);

  localparam int TW  = $clog2(MAX_TRIES + 1);
  localparam int LCW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

  if (MAX_TRIES < 1 || LOCKOUT_CYC < 1 || RELOCK_CYC < 1) begin : g_bad_param
    $error("auto_lock_fsm: MAX_TRIES, LOCKOUT_CYC and RELOCK_CYC must be >= 1");
  end

  lock_state_e state_q, state_d;
  logic [TW-1:0] tries_q, tries_d;
  logic [LCW-1:0] lcnt_q, lcnt_d;
  logic relock;

`ifdef HOME_AUTO_RELOCK_EN
  localparam int RCW = (RELOCK_CYC > 1) ? $clog2(RELOCK_CYC) : 1;
  logic [RCW-1:0] idle_q, idle_d;

  assign relock = (state_q == UNLOCKED) && !act_i && (idle_q == RCW'(RELOCK_CYC - 1));

  always_comb begin
    idle_d = '0;
    if (state_q == UNLOCKED && !act_i && idle_q != RCW'(RELOCK_CYC - 1))
      idle_d = idle_q + RCW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  assign relock = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    lcnt_d  = lcnt_q;
    unique case (state_q)
      LOCKED: begin
        if (pass_valid_i) begin
          if (pass_in_i == PASS) begin
            state_d = UNLOCKED;
            tries_d = TW'(MAX_TRIES);
          end else if (tries_q > TW'(1)) begin
            tries_d = tries_q - TW'(1);
          end else begin
            state_d = LOCKOUT;
            tries_d = '0;
            lcnt_d  = LCW'(LOCKOUT_CYC - 1);
          end
        end
      end
      UNLOCKED: begin
        if (lock_req_i || relock) state_d = LOCKED;
      end
      LOCKOUT: begin
        if (lcnt_q == '0) begin
          state_d = LOCKED;
          tries_d = TW'(MAX_TRIES);
        end else begin
          lcnt_d = lcnt_q - LCW'(1);
        end
      end
      default: state_d = LOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOCKED;
      tries_q <= TW'(MAX_TRIES);
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      lcnt_q  <= lcnt_d;
    end
  end

  assign state_o      = state_q;
  assign state_d_o    = state_d;
  assign tries_left_o = tries_q;

endmodule

// File: rtl/home_auto_seq_ctrl.sv
// Home-automation controller top: lock FSM plus climate and light datapaths.
// Optional inactivity relock is enabled by defining HOME_AUTO_RELOCK_EN.
module home_auto_seq_ctrl
  import home_auto_pkg::*;
#(
  parameter int DW = 4,
  parameter int NLIGHT = 4,
  parameter logic [DW-1:0] PASS = 4'b0010,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYC = 16,
  parameter int IDLE_TEMP = 6,
  parameter int IDLE_LIGHT = 8,
  parameter int FAN_ON = 7,
  parameter int AC_ON = 11,
  parameter int HYST = 1,
  parameter int RELOCK_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [DW-1:0] pass_in_i,
  input  logic pass_valid_i,
  input  logic lock_req_i,
  input  logic [DW-1:0] temp_i,
  input  logic temp_valid_i,
  input  logic [NLIGHT*DW-1:0] light_lvl_i,
  output logic unlocked_o,
  output logic alarm_o,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left_o,
  output logic fan_o,
  output logic ac_o,
  output logic wind_o,
  output logic [DW-1:0] fan_speed_o,
  output logic [NLIGHT*DW-1:0] light_out_o
);

  if (AC_ON <= FAN_ON) begin : g_bad_param
    $error("home_auto_seq_ctrl: AC_ON must be above FAN_ON");
  end

  localparam logic [DW-1:0] FAN_ON_C  = DW'(FAN_ON);
  localparam logic [DW-1:0] AC_ON_C   = DW'(AC_ON);
  localparam logic [DW-1:0] FAN_OFF_C = DW'(FAN_ON - 1 - HYST);
  localparam logic [DW-1:0] AC_OFF_C  = DW'(AC_ON - 1 - HYST);

  lock_state_e state, state_nxt;
  logic unl_d;

`ifdef HOME_AUTO_RELOCK_EN
  logic [NLIGHT*DW-1:0] light_prev_q;
  logic act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) light_prev_q <= '0;
    else        light_prev_q <= light_lvl_i;
  end

  assign act = pass_valid_i | temp_valid_i | (light_lvl_i != light_prev_q);
`endif

  auto_lock_fsm #(
    .DW(DW), .PASS(PASS), .MAX_TRIES(MAX_TRIES),
    .LOCKOUT_CYC(LOCKOUT_CYC), .RELOCK_CYC(RELOCK_CYC)
  ) u_lock (
    .clk(clk),
    .rst_n(rst_n),
    .pass_in_i(pass_in_i),
    .pass_valid_i(pass_valid_i),
    .lock_req_i(lock_req_i),
`ifdef HOME_AUTO_RELOCK_EN
    .act_i(act),
`endif
    .state_o(state),
    .state_d_o(state_nxt),
    .tries_left_o(tries_left_o)
  );

  // Gating on the next lock state blanks every output in the same cycle unlocked drops.
  assign unl_d = (state_nxt == UNLOCKED);

  logic [DW-1:0] temp_q, fan_speed_q, fan_speed_d;
  climate_mode_e mode_q, mode_d;
  logic fan_q, ac_q;
  logic [NLIGHT*DW-1:0] light_q, light_d;

  always_comb begin
    mode_d = mode_q;
    if (!unl_d) begin
      mode_d = OFF;
    end else if (temp_q >= AC_ON_C) begin
      mode_d = AC;
    end else begin
      unique case (mode_q)
        OFF: if (temp_q >= FAN_ON_C) mode_d = FAN;
        FAN: if (temp_q <= FAN_OFF_C) mode_d = OFF;
        AC: begin
          if (temp_q <= FAN_OFF_C)     mode_d = OFF;
          else if (temp_q <= AC_OFF_C) mode_d = FAN;
        end
        default: mode_d = OFF;
      endcase
    end
  end

  always_comb begin
    fan_speed_d = '0;
    if (mode_d == FAN) fan_speed_d = DW'(sat_sub(32'(temp_q), IDLE_TEMP));
  end

  always_comb begin
    light_d = '0;
    if (unl_d) begin
      for (int i = 0; i < NLIGHT; i++)
        light_d[i*DW +: DW] = DW'(sat_sub(IDLE_LIGHT, 32'(light_lvl_i[i*DW +: DW])));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_q      <= '0;
      mode_q      <= OFF;
      fan_q       <= 1'b0;
      ac_q        <= 1'b0;
      fan_speed_q <= '0;
      light_q     <= '0;
    end else begin
      if (temp_valid_i) temp_q <= temp_i;
      mode_q      <= mode_d;
      fan_q       <= (mode_d == FAN);
      ac_q        <= (mode_d == AC);
      fan_speed_q <= fan_speed_d;
      light_q     <= light_d;
    end
  end

  assign unlocked_o  = (state == UNLOCKED);
  assign alarm_o     = (state == LOCKOUT);
  assign fan_o       = fan_q;
  assign wind_o      = fan_q;
  assign ac_o        = ac_q;
  assign fan_speed_o = fan_speed_q;
  assign light_out_o = light_q;

endmodule

// File: tb/tb_home_auto_seq_ctrl.sv
// Self-checking bench for home_auto_seq_ctrl: directed scenarios plus random
// stimulus against a cycle-level behavioural model.
module tb_home_auto_seq_ctrl;

  localparam int DW = 4, NL = 4, PASS = 2, MAXT = 3, LOCK_CYC = 16;
  localparam int IDLE_T = 6, IDLE_L = 8, FAN_ON = 7, AC_ON = 11, HYST = 1, RELOCK = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic [DW-1:0] pass_in, temp;
  logic pass_valid, lock_req, temp_valid;
  logic [NL*DW-1:0] light_lvl;
  logic unlocked, alarm, fan, ac, wind;
  logic [1:0] tries_left;
  logic [DW-1:0] fan_speed;
  logic [NL*DW-1:0] light_out;

  int errors = 0;
  int checks = 0;

  // model: st 0=locked 1=unlocked 2=lockout, mode 0=off 1=fan 2=ac
  int m_st, m_tries, m_cnt, m_temp, m_mode, m_speed, m_idle;
  int m_light[NL];
  logic [NL*DW-1:0] m_prev;

  always #5 clk = ~clk;

  home_auto_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .pass_in_i(pass_in), .pass_valid_i(pass_valid), .lock_req_i(lock_req),
    .temp_i(temp), .temp_valid_i(temp_valid), .light_lvl_i(light_lvl),
    .unlocked_o(unlocked), .alarm_o(alarm), .tries_left_o(tries_left),
    .fan_o(fan), .ac_o(ac), .wind_o(wind),
    .fan_speed_o(fan_speed), .light_out_o(light_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int a, input int b);
    return (a > b) ? a - b : 0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_tries = MAXT; m_cnt = 0; m_temp = 0; m_mode = 0; m_speed = 0; m_idle = 0;
    m_prev = '0;
    for (int i = 0; i < NL; i++) m_light[i] = 0;
  endtask

  task automatic model_edge();
    int ns, nm, t;
    bit act;
    ns = m_st;
    t  = m_temp;
    act = pass_valid || temp_valid || (light_lvl != m_prev);
    if (m_st == 0) begin
      if (pass_valid) begin
        if (int'(pass_in) == PASS) begin ns = 1; m_tries = MAXT; end
        else if (m_tries > 1) m_tries--;
        else begin ns = 2; m_tries = 0; m_cnt = LOCK_CYC - 1; end
      end
    end else if (m_st == 1) begin
      if (lock_req) ns = 0;
`ifdef HOME_AUTO_RELOCK_EN
      else if (!act && m_idle == RELOCK - 1) ns = 0;
`endif
    end else begin
      if (m_cnt == 0) begin ns = 0; m_tries = MAXT; end
      else m_cnt--;
    end
    m_idle = (m_st != 1 || act || m_idle == RELOCK - 1) ? 0 : m_idle + 1;
    // climate rules: rising thresholds first, then hysteresis on the way down
    if (ns != 1) nm = 0;
    else if (t >= AC_ON) nm = 2;
    else if (m_mode == 0) nm = (t >= FAN_ON) ? 1 : 0;
    else if (t <= FAN_ON - 1 - HYST) nm = 0;
    else if (m_mode == 2 && t <= AC_ON - 1 - HYST) nm = 1;
    else nm = m_mode;
    m_speed = (nm == 1) ? sat(t, IDLE_T) : 0;
    for (int i = 0; i < NL; i++)
      m_light[i] = (ns == 1) ? sat(IDLE_L, int'(light_lvl[i*DW +: DW])) : 0;
    if (temp_valid) m_temp = int'(temp);
    m_prev = light_lvl;
    m_st = ns;
    m_mode = nm;
  endtask

  task automatic compare_all();
    logic [NL*DW-1:0] el;
    for (int i = 0; i < NL; i++) el[i*DW +: DW] = DW'(m_light[i]);
    chk("unlocked", 32'(unlocked), 32'(m_st == 1));
    chk("alarm", 32'(alarm), 32'(m_st == 2));
    chk("tries_left", 32'(tries_left), m_tries);
    chk("fan", 32'(fan), 32'(m_mode == 1));
    chk("wind", 32'(wind), 32'(m_mode == 1));
    chk("ac", 32'(ac), 32'(m_mode == 2));
    chk("fan_speed", 32'(fan_speed), m_speed);
    chk("light_out", 32'(light_out), 32'(el));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic quiet();
    pass_valid = 1'b0; lock_req = 1'b0; temp_valid = 1'b0;
  endtask

  int tseq[6] = '{6, 7, 11, 10, 9, 5};
  int eacm[6] = '{0, 1, 2, 2, 1, 0};
  int espd[6] = '{0, 1, 0, 0, 3, 0};

  initial begin
    rst_n = 1'b0; pass_in = '0; temp = '0; light_lvl = '0;
    quiet();
    model_reset();
    #12;
    compare_all();
    @(negedge clk); rst_n = 1'b1;

    // unlock with the correct code
    pass_in = 4'd2; pass_valid = 1'b1;
    step();
    quiet();
    chk("unlock", 32'(unlocked), 1);
    chk("unlock_tries", 32'(tries_left), 3);

    // temperature walk with hysteresis
    for (int k = 0; k < 6; k++) begin
      temp = 4'(tseq[k]); temp_valid = 1'b1;
      step();
      temp_valid = 1'b0;
      step();
      chk("seq_speed", 32'(fan_speed), espd[k]);
      chk("seq_fan", 32'(fan), 32'(eacm[k] == 1));
      chk("seq_ac", 32'(ac), 32'(eacm[k] == 2));
    end

    // light compensation, then relock blanks everything
    light_lvl = 16'h0C83;
    step();
    chk("light_comp", 32'(light_out), 32'h8005);
    temp = 4'd9; temp_valid = 1'b1;
    step();
    temp_valid = 1'b0;
    step();
    chk("fan_before_lock", 32'(fan), 1);
    lock_req = 1'b1;
    step();
    quiet();
    chk("lock_light", 32'(light_out), 0);
    chk("lock_fan", 32'(fan | ac | wind), 0);

    // lock_req wins over a correct code while unlocked
    pass_in = 4'd2; pass_valid = 1'b1;
    step();
    lock_req = 1'b1;
    step();
    quiet();
    chk("lock_wins", 32'(unlocked), 0);

    // three wrong codes then a 16-cycle lockout that ignores the right code
    pass_in = 4'd5; pass_valid = 1'b1;
    step(); chk("tries_2", 32'(tries_left), 2);
    step(); chk("tries_1", 32'(tries_left), 1);
    step(); chk("tries_0", 32'(tries_left), 0);
    chk("alarm_on", 32'(alarm), 1);
    pass_in = 4'd2;
    for (int k = 0; k < LOCK_CYC - 1; k++) step();
    chk("alarm_held", 32'(alarm), 1);
    step();
    quiet();
    chk("alarm_off", 32'(alarm), 0);
    chk("tries_reload", 32'(tries_left), 3);
    chk("no_unlock", 32'(unlocked), 0);

    // reset in the middle of lockout
    pass_in = 4'd5; pass_valid = 1'b1;
    repeat (3) step();
    quiet();
    repeat (4) step();
    @(negedge clk); rst_n = 1'b0; #1;
    model_reset();
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_tries", 32'(tries_left), 3);
    compare_all();
    @(negedge clk); rst_n = 1'b1;

`ifdef HOME_AUTO_RELOCK_EN
    pass_in = 4'd2; pass_valid = 1'b1;
    step();
    quiet();
    repeat (RELOCK - 1) step();
    chk("relock_hold", 32'(unlocked), 1);
    step();
    chk("relock_drop", 32'(unlocked), 0);
    pass_valid = 1'b1;
    step();
    quiet();
    for (int k = 1; k < RELOCK; k++) begin
      temp_valid = (k == 40);
      step();
    end
    temp_valid = 1'b0;
    chk("relock_kick", 32'(unlocked), 1);
`endif

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      pass_in    = DW'($urandom_range(0, 3));
      pass_valid = ($urandom_range(0, 3) == 0);
      lock_req   = ($urandom_range(0, 24) == 0);
      temp       = DW'($urandom_range(0, 15));
      temp_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) light_lvl = NL*DW'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
